// File: rtl/bnn_img_pkg.sv
// Purpose: constants and state encoding shared by the image write path and the readback streamer.
// Latency: n/a (package only).
// Backpressure: n/a.
package bnn_img_pkg;
    localparam int IMG_BYTES  = 113;            // bytes per image; byte i = img[i*8 +: 8]
    localparam int TOTAL_BITS = IMG_BYTES * 8;  // 904-bit flattened image
    localparam int ADDR_W     = 7;              // byte pointer / tx_addr width

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        CKSUM,
        FINISH
    } stream_state_t;
endpackage

// File: rtl/image_byte_streamer_if.sv
// Purpose: byte-wide TX link (valid/ready) carrying image bytes and their index.
// Latency: n/a (wires only).
// Backpressure: sink deasserts tx_ready; source holds tx_data/tx_addr until accepted.
// Ports: tx_data (byte), tx_valid, tx_ready, tx_addr (byte index).
interface image_byte_streamer_if;
    import bnn_img_pkg::*;

    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [ADDR_W-1:0] tx_addr;

    modport master (output tx_data, output tx_valid, output tx_addr, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, input  tx_addr, output tx_ready);
endinterface

// File: rtl/image_byte_streamer.sv
// Purpose: snapshot the 904-bit image on start and stream it out byte 0 first over a valid/ready link.
// Latency: first byte valid the cycle after start is sampled; done pulses the cycle after the last byte is accepted.
// Backpressure: tx_data/tx_addr hold while tx_valid && !tx_ready; nothing dropped or retracted.
// Ports: clk, rst_n (async, active-low), start, abort, img_in[903:0], tx (master modport:
//        tx_data, tx_valid, tx_ready, tx_addr), busy, done.
// Option: define IMG_STREAM_CHECKSUM_EN to append one XOR-of-all-bytes byte at tx_addr=113.
module image_byte_streamer
    import bnn_img_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [TOTAL_BITS-1:0]   img_in,
    image_byte_streamer_if.master   tx,
    output logic                    busy,
    output logic                    done
);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(IMG_BYTES - 1);

    stream_state_t                state, state_nxt;
    logic [IMG_BYTES-1:0][7:0]    shadow;
    logic [ADDR_W-1:0]            ptr;
    logic [7:0]                   cur_byte;
    logic                         byte_hs;
    logic                         capture;

    assign cur_byte = shadow[ptr];
    assign byte_hs  = (state == STREAM) && tx.tx_ready;
    // abort beats start when both arrive in IDLE
    assign capture  = (state == IDLE) && start && !abort;

`ifdef IMG_STREAM_CHECKSUM_EN
    logic [7:0] cksum;

    // running XOR of accepted bytes; complete once byte 112 has been taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum <= '0;
        end else if (abort || capture) begin
            cksum <= '0;
        end else if (byte_hs) begin
            cksum <= cksum ^ cur_byte;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shadow <= '0;
            ptr    <= '0;
        end else begin
            state <= state_nxt;
            if (abort) begin
                ptr <= '0;
            end else if (capture) begin
                shadow <= img_in;
                ptr    <= '0;
            end else if (byte_hs && ptr != LAST_PTR) begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        tx.tx_valid = 1'b0;
        tx.tx_data  = 8'h00;
        tx.tx_addr  = '0;
        busy        = (state != IDLE);
        done        = 1'b0;

        case (state)
            IDLE: begin
                if (start) state_nxt = STREAM;
            end
            STREAM: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = cur_byte;
                tx.tx_addr  = ptr;
                if (byte_hs && ptr == LAST_PTR) begin
`ifdef IMG_STREAM_CHECKSUM_EN
                    state_nxt = CKSUM;
`else
                    state_nxt = FINISH;
`endif
                end
            end
`ifdef IMG_STREAM_CHECKSUM_EN
            CKSUM: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = cksum;
                tx.tx_addr  = ADDR_W'(IMG_BYTES);
                if (tx.tx_ready) state_nxt = FINISH;
            end
`endif
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (abort) state_nxt = IDLE;
    end
endmodule

// File: tb/tb_image_byte_streamer.sv
// Purpose: directed self-checking bench for image_byte_streamer (streaming, stalls, ignored start, abort, reset).
// Latency: checks first byte one cycle after start and done one cycle after the last accepted byte.
// Backpressure: tx_ready driven per cycle; expected index only advances on an accepted byte.
module tb_image_byte_streamer;
    import bnn_img_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic                  abort;
    logic [TOTAL_BITS-1:0] img_in;
    logic                  busy;
    logic                  done;

    int checks   = 0;
    int failures = 0;

    image_byte_streamer_if sif();

    image_byte_streamer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .img_in (img_in),
        .tx     (sif),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // step to just after the next rising edge; inputs change and outputs are sampled here
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TOTAL_BITS-1:0] make_img(input bit incr, input logic [7:0] fill);
        logic [TOTAL_BITS-1:0] r;
        for (int i = 0; i < IMG_BYTES; i++) r[i*8 +: 8] = incr ? 8'(i) : fill;
        return r;
    endfunction

    task automatic kick();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_vld"},  sif.tx_valid, 32'd0);
        check_eq({tag, "_dat"},  sif.tx_data,  32'd0);
        check_eq({tag, "_addr"}, sif.tx_addr,  32'd0);
        check_eq({tag, "_busy"}, busy,         32'd0);
        check_eq({tag, "_done"}, done,         32'd0);
    endtask

    // stop_kind: 0 none, 1 abort at stop_at, 2 reset at stop_at
    task automatic stream_check(input string tag, input bit incr, input logic [7:0] fill,
                                input bit rnd_ready, input int poke_at,
                                input int stop_at, input int stop_kind);
        int         idx;
        int         budget;
        bit         rdy;
        bit         poked;
        logic [7:0] exp_b;
        logic [7:0] xacc;
        idx = 0; budget = 0; xacc = 8'h00; poked = 1'b0;
        while (idx < IMG_BYTES && budget < 1000) begin
            exp_b = incr ? 8'(idx) : fill;
            rdy   = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            sif.tx_ready = rdy;
            start = 1'b0;
            if (idx == poke_at && !poked) begin
                img_in = '0;
                start  = 1'b1;
                poked  = 1'b1;
            end
            check_eq({tag, "_vld"},  sif.tx_valid, 32'd1);
            check_eq({tag, "_dat"},  sif.tx_data,  32'(exp_b));
            check_eq({tag, "_addr"}, sif.tx_addr,  32'(idx));
            check_eq({tag, "_busy"}, busy,         32'd1);
            check_eq({tag, "_done"}, done,         32'd0);
            if (idx == stop_at && stop_kind == 1) begin
                abort = 1'b1;
                cyc();
                abort = 1'b0;
                check_quiet({tag, "_abort"});
                repeat (3) begin
                    cyc();
                    check_eq({tag, "_abort_nodone"}, done, 32'd0);
                end
                return;
            end
            if (idx == stop_at && stop_kind == 2) begin
                #2 rst_n = 1'b0;
                #1 check_quiet({tag, "_rst"});
                cyc();
                cyc();
                rst_n = 1'b1;
                cyc();
                check_quiet({tag, "_rst_idle"});
                return;
            end
            cyc();
            budget++;
            if (rdy) begin
                xacc ^= exp_b;
                idx++;
            end
        end
        start = 1'b0;
        sif.tx_ready = 1'b1;
        check_eq({tag, "_count"}, 32'(idx), 32'(IMG_BYTES));
`ifdef IMG_STREAM_CHECKSUM_EN
        check_eq({tag, "_ck_vld"},  sif.tx_valid, 32'd1);
        check_eq({tag, "_ck_addr"}, sif.tx_addr,  32'(IMG_BYTES));
        check_eq({tag, "_ck_dat"},  sif.tx_data,  32'(xacc));
        cyc();
`endif
        check_eq({tag, "_fin_done"}, done,         32'd1);
        check_eq({tag, "_fin_busy"}, busy,         32'd1);
        check_eq({tag, "_fin_vld"},  sif.tx_valid, 32'd0);
        cyc();
        check_quiet({tag, "_after"});
        repeat (3) begin
            cyc();
            check_eq({tag, "_one_done"}, done, 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        img_in = '0;
        sif.tx_ready = 1'b0;
        #3 check_quiet("reset");
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        check_quiet("idle");

        // abort and start together in IDLE: stays idle
        img_in = make_img(1'b1, 8'h00);
        start = 1'b1;
        abort = 1'b1;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        check_quiet("start_abort");
        cyc();

        // 1: ramp image, ready high
        img_in = make_img(1'b1, 8'h00);
        kick();
        stream_check("t1", 1'b1, 8'h00, 1'b0, -1, -1, 0);

        // 2: constant 0xA5 with random stalls
        img_in = make_img(1'b0, 8'hA5);
        kick();
        stream_check("t2", 1'b0, 8'hA5, 1'b1, -1, -1, 0);

        // 3: image zeroed and start repulsed at byte 40
        img_in = make_img(1'b1, 8'h00);
        kick();
        stream_check("t3", 1'b1, 8'h00, 1'b0, 40, -1, 0);

        // 4: abort at byte 57, then a fresh transfer from byte 0
        img_in = make_img(1'b1, 8'h00);
        kick();
        stream_check("t4", 1'b1, 8'h00, 1'b0, -1, 57, 1);
        kick();
        stream_check("t4b", 1'b1, 8'h00, 1'b0, -1, -1, 0);

        // 5: reset asserted mid-stream at byte 20, then a full transfer
        kick();
        stream_check("t5", 1'b1, 8'h00, 1'b0, -1, 20, 2);
        img_in = make_img(1'b0, 8'h3C);
        kick();
        stream_check("t5b", 1'b0, 8'h3C, 1'b0, -1, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
